// File: rtl/bcp_dispatcher.sv
// bcp_dispatcher: walks one variable's clause-table range into the BCP pipeline,
// keeping at most PIPE_DEPTH clauses in flight, and merges the returned conflict flags.
module bcp_dispatcher #(
    parameter int PIPE_DEPTH        = 4,
    parameter int OUT_BITS          = 4,
    parameter int MAX_VARS_BITS     = 8,
    parameter int CLAUSE_TABLE_BITS = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         bcp_en,
    input  logic [MAX_VARS_BITS-1:0]     var_in,
    input  logic                         abort,
    output logic                         read_var_start_end,
    output logic [MAX_VARS_BITS-1:0]     var_in_vse,
    input  logic [CLAUSE_TABLE_BITS-1:0] start_clause,
    input  logic [CLAUSE_TABLE_BITS-1:0] end_clause,
    output logic                         issue_valid,
    output logic [CLAUSE_TABLE_BITS-1:0] issue_idx,
    input  logic                         issue_ready,
    input  logic                         res_valid,
    input  logic                         res_conflict,
    output logic                         bcp_busy,
    output logic                         conflict,
    output logic                         done
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOOKUP = 3'd1;
    localparam logic [2:0] S_ISSUE  = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [OUT_BITS-1:0]          DEPTH   = OUT_BITS'(PIPE_DEPTH);
    localparam logic [OUT_BITS-1:0]          OUT_ONE = OUT_BITS'(1);
    localparam logic [CLAUSE_TABLE_BITS-1:0] IDX_ONE = CLAUSE_TABLE_BITS'(1);

    logic [2:0]                   state;
    logic [2:0]                   state_next;
    logic [CLAUSE_TABLE_BITS-1:0] cur;
    logic [CLAUSE_TABLE_BITS-1:0] end_idx;
    logic [MAX_VARS_BITS-1:0]     var_q;
    logic [OUT_BITS-1:0]          outstanding;
    logic                         conflict_q;
    logic                         can_issue;
    logic                         handshake;
    logic                         retire;
    logic                         in_run;

    // The issue gate looks only at registered state: no same-cycle credit from a retiring result.
    assign can_issue = (state == S_ISSUE) && (outstanding < DEPTH) && !conflict_q;
    assign handshake = can_issue && issue_ready;
    assign retire    = res_valid && (outstanding != '0);
    assign in_run    = (state == S_LOOKUP) || (state == S_ISSUE) || (state == S_DRAIN);

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (bcp_en) state_next = S_LOOKUP;
            S_LOOKUP: state_next = (start_clause >= end_clause) ? S_DONE : S_ISSUE;
            S_ISSUE:  if (conflict_q || (handshake && ((cur + IDX_ONE) == end_idx)))
                          state_next = S_DRAIN;
            S_DRAIN:  if ((outstanding == '0) && !res_valid) state_next = S_DONE;
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
        if (abort) state_next = S_IDLE;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_IDLE;
            cur         <= '0;
            end_idx     <= '0;
            var_q       <= '0;
            outstanding <= '0;
            conflict_q  <= 1'b0;
        end else begin
            state <= state_next;
            if (abort) begin
                outstanding <= '0;
                conflict_q  <= 1'b0;
            end else begin
                if (handshake && !retire)
                    outstanding <= outstanding + OUT_ONE;
                else if (!handshake && retire)
                    outstanding <= outstanding - OUT_ONE;
                if (in_run && res_valid && res_conflict)
                    conflict_q <= 1'b1;
                if (state == S_LOOKUP) begin
                    cur     <= start_clause;
                    end_idx <= end_clause;
                end
                if (handshake)
                    cur <= cur + IDX_ONE;
                // A new run starts clean; this overrides anything a stray result did above.
                if ((state == S_IDLE) && bcp_en) begin
                    var_q       <= var_in;
                    conflict_q  <= 1'b0;
                    outstanding <= '0;
                end
            end
        end
    end

    assign read_var_start_end = (state == S_LOOKUP) && !reset;
    assign var_in_vse         = var_q;
    assign issue_valid        = can_issue && !reset;
    assign issue_idx          = cur;
    assign bcp_busy           = (state != S_IDLE) && !reset;
    assign conflict           = conflict_q && !reset;
    assign done               = (state == S_DONE) && !reset && !abort;

endmodule

// File: tb/tb_bcp_dispatcher.sv
// tb_bcp_dispatcher: scoreboard bench; a monitor models the dispatcher at run level
// (index queue, in-flight count, sticky conflict) and checks every cycle against the DUT.
module tb_bcp_dispatcher;

    localparam int DEPTH = 3;
    localparam int OB    = 2;
    localparam int VB    = 8;
    localparam int CB    = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          bcp_en;
    logic [VB-1:0] var_in;
    logic          abort;
    logic          read_var_start_end;
    logic [VB-1:0] var_in_vse;
    logic [CB-1:0] start_clause;
    logic [CB-1:0] end_clause;
    logic          issue_valid;
    logic [CB-1:0] issue_idx;
    logic          issue_ready;
    logic          res_valid;
    logic          res_conflict;
    logic          bcp_busy;
    logic          conflict;
    logic          done;

    bcp_dispatcher #(
        .PIPE_DEPTH(DEPTH), .OUT_BITS(OB), .MAX_VARS_BITS(VB), .CLAUSE_TABLE_BITS(CB)
    ) dut (
        .clock(clock), .reset(reset), .bcp_en(bcp_en), .var_in(var_in), .abort(abort),
        .read_var_start_end(read_var_start_end), .var_in_vse(var_in_vse),
        .start_clause(start_clause), .end_clause(end_clause),
        .issue_valid(issue_valid), .issue_idx(issue_idx), .issue_ready(issue_ready),
        .res_valid(res_valid), .res_conflict(res_conflict),
        .bcp_busy(bcp_busy), .conflict(conflict), .done(done)
    );

    always #5 clock = ~clock;

    logic [CB-1:0] tbl_start [256];
    logic [CB-1:0] tbl_end   [256];
    assign start_clause = tbl_start[var_in_vse];
    assign end_clause   = tbl_end[var_in_vse];

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    // Knobs set by the stimulus process, read by the monitor.
    bit hold       = 1'b0;
    bit rdy_rand   = 1'b0;
    bit ready_low  = 1'b0;
    bit timed      = 1'b0;
    int stall_until = 0;
    int latency    = 3;
    int conf_idx   = -1;

    // Run-level reference model, owned by the monitor.
    bit m_busy = 1'b0;
    bit m_conf = 1'b0;
    bit m_empty = 1'b0;
    int m_out = 0;
    int m_var = 0;
    int m_run_cyc = 0;
    int m_lookup_cyc = -10;
    int n_issued = 0;
    int done_count = 0;
    int exp_q[$];
    int pq_idx[$];
    int pq_due[$];
    bit pq_conf[$];

    task automatic check_eq(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_output();
        check_eq("rst_read_strobe", read_var_start_end, 0);
        check_eq("rst_var_in_vse", var_in_vse, 0);
        check_eq("rst_issue_valid", issue_valid, 0);
        check_eq("rst_issue_idx", issue_idx, 0);
        check_eq("rst_busy", bcp_busy, 0);
        check_eq("rst_conflict", conflict, 0);
        check_eq("rst_done", done, 0);
    endtask

    // Monitor: drives the pipeline side, then samples and compares against the model.
    initial begin : monitor
        bit hs;
        bit ret;
        bit n_busy;
        bit n_conf;
        int n_out;
        bit prev_stall;
        int prev_idx;
        int exp_idx;
        prev_stall = 1'b0;
        prev_idx   = 0;
        issue_ready  = 1'b1;
        res_valid    = 1'b0;
        res_conflict = 1'b0;
        forever begin
            @(negedge clock);
            if (ready_low || (cyc < stall_until)) issue_ready = 1'b0;
            else if (rdy_rand) issue_ready = ($urandom_range(0, 3) != 0);
            else issue_ready = 1'b1;
            if (!hold && pq_due.size() > 0 && pq_due[0] <= cyc) begin
                res_valid    = 1'b1;
                res_conflict = pq_conf[0];
                void'(pq_idx.pop_front());
                void'(pq_due.pop_front());
                void'(pq_conf.pop_front());
            end else begin
                res_valid    = 1'b0;
                res_conflict = 1'b0;
            end
            #1;
            if (reset) begin
                m_busy = 1'b0; m_conf = 1'b0; m_out = 0; prev_stall = 1'b0;
                exp_q.delete(); pq_idx.delete(); pq_due.delete(); pq_conf.delete();
            end else begin
                hs = issue_valid && issue_ready;
                check_eq("busy", bcp_busy, m_busy);
                check_eq("conflict", conflict, m_conf);
                check_eq("read_strobe", read_var_start_end, m_busy && (cyc == m_lookup_cyc));
                if (read_var_start_end) check_eq("vse_addr", var_in_vse, m_var);
                if (exp_q.size() == 0) check_eq("valid_nothing_left", issue_valid, 0);
                if (m_conf) check_eq("valid_after_conflict", issue_valid, 0);
                if (m_out >= DEPTH) check_eq("valid_at_depth", issue_valid, 0);
                if (prev_stall && issue_valid) check_eq("stall_idx_hold", issue_idx, prev_idx);
                if (hs && exp_q.size() > 0) begin
                    exp_idx = exp_q.pop_front();
                    check_eq("issue_idx", issue_idx, exp_idx);
                    if (timed && n_issued < DEPTH)
                        check_eq("issue_cycle", cyc - m_run_cyc, 2 + n_issued);
                    n_issued++;
                end
                if (hs) begin
                    pq_idx.push_back(int'(issue_idx));
                    pq_due.push_back(cyc + latency);
                    pq_conf.push_back(int'(issue_idx) == conf_idx);
                end
                prev_stall = issue_valid && !issue_ready;
                prev_idx   = int'(issue_idx);
                if (!m_busy || m_out != 0 || (exp_q.size() > 0 && !m_conf))
                    check_eq("done_premature", done, 0);
                if (done) begin
                    done_count++;
                    if (m_empty) check_eq("empty_done_cycle", cyc - m_run_cyc, 2);
                end
                ret    = res_valid && (m_out > 0);
                n_out  = m_out + int'(hs) - int'(ret);
                n_conf = m_conf || (res_valid && res_conflict && m_busy && !done);
                n_busy = m_busy && !done;
                if (bcp_en && !m_busy && !abort) begin
                    n_busy = 1'b1; n_conf = 1'b0; n_out = 0;
                    m_run_cyc = cyc; m_lookup_cyc = cyc + 1; m_var = int'(var_in);
                    n_issued = 0;
                    exp_q.delete();
                    for (int i = int'(tbl_start[var_in]); i < int'(tbl_end[var_in]); i++)
                        exp_q.push_back(i);
                    m_empty = (tbl_start[var_in] >= tbl_end[var_in]);
                end
                if (abort) begin
                    n_busy = 1'b0; n_conf = 1'b0; n_out = 0;
                    exp_q.delete();
                end
                m_busy = n_busy; m_conf = n_conf; m_out = n_out;
            end
        end
    end

    task automatic apply_stimulus(input int v, input int s, input int e, input int lat,
                                  input int cidx);
        tbl_start[v] = CB'(s);
        tbl_end[v]   = CB'(e);
        latency      = lat;
        conf_idx     = cidx;
        @(negedge clock);
        bcp_en = 1'b1;
        var_in = VB'(v);
        @(negedge clock);
        bcp_en = 1'b0;
    endtask

    task automatic do_reset(input int n, input bit chk);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        #2;
        if (chk) check_output();
        repeat (n - 1) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles);
        int start_cnt = done_count;
        bit got = 1'b0;
        for (int i = 0; i < max_cycles && !got; i++) begin
            @(posedge clock);
            if (done_count != start_cnt) got = 1'b1;
        end
        check_eq("run_completed", got, 1);
        if (!got) do_reset(2, 1'b0);
    endtask

    initial begin : stimulus
        bit seen;
        int s, e, cidx;
        for (int i = 0; i < 256; i++) begin
            tbl_start[i] = '0;
            tbl_end[i]   = '0;
        end
        bcp_en = 1'b0; var_in = '0; abort = 1'b0;
        do_reset(3, 1'b1);
        repeat (2) @(negedge clock);

        // Range case: two clauses, results three cycles after issue.
        timed = 1'b1;
        apply_stimulus(101, 0, 2, 3, -1);
        wait_done(40);
        timed = 1'b0;
        repeat (3) @(negedge clock);

        // Back-pressure: no results for 10 cycles, then a ready stall while valid.
        hold = 1'b1;
        apply_stimulus(7, 5, 9, 2, -1);
        repeat (10) @(negedge clock);
        #2;
        check_eq("bp_issue_count", n_issued, DEPTH);
        check_eq("bp_valid_low", issue_valid, 0);
        stall_until = cyc + 6;
        hold = 1'b0;
        wait_done(60);
        repeat (2) @(negedge clock);

        // Early stop on conflict; a bcp_en during the run must be ignored.
        apply_stimulus(3, 0, 8, 3, 1);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clock);
            if (m_conf) seen = 1'b1;
        end
        check_eq("conflict_reached", seen, 1);
        @(negedge clock);
        bcp_en = 1'b1; var_in = 8'd50;
        @(negedge clock);
        bcp_en = 1'b0;
        wait_done(60);
        repeat (4) @(negedge clock);
        #2;
        check_eq("conflict_held_idle", conflict, 1);

        // Empty ranges, equal and inverted.
        apply_stimulus(10, 3, 3, 1, -1);
        wait_done(10);
        apply_stimulus(11, 4, 2, 1, -1);
        wait_done(10);
        repeat (2) @(negedge clock);

        // Abort with DEPTH clauses in flight; late results (one conflicting) must be ignored.
        hold = 1'b1;
        apply_stimulus(20, 0, 10, 2, 1);
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(posedge clock);
            if (m_out == DEPTH) seen = 1'b1;
        end
        check_eq("abort_fill", seen, 1);
        @(negedge clock);
        ready_low = 1'b1; abort = 1'b1;
        @(negedge clock);
        abort = 1'b0; ready_low = 1'b0;
        #2;
        check_eq("abort_busy", bcp_busy, 0);
        check_eq("abort_done", done, 0);
        check_eq("abort_conflict", conflict, 0);
        hold = 1'b0;
        repeat (8) @(negedge clock);
        apply_stimulus(21, 2, 6, 1, -1);
        wait_done(40);
        repeat (2) @(negedge clock);

        // Reset while draining.
        hold = 1'b1;
        apply_stimulus(30, 0, 2, 2, -1);
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(posedge clock);
            if (n_issued == 2) seen = 1'b1;
        end
        check_eq("drain_reached", seen, 1);
        repeat (2) @(negedge clock);
        do_reset(2, 1'b1);
        hold = 1'b0;
        apply_stimulus(31, 1, 4, 2, -1);
        wait_done(40);

        // Randomized runs with random ready, latency, ranges and conflict position.
        rdy_rand = 1'b1;
        for (int r = 0; r < 12; r++) begin
            s = $urandom_range(0, 15);
            e = $urandom_range(0, 15);
            cidx = ($urandom_range(0, 2) == 0) ? s + $urandom_range(0, 3) : -1;
            apply_stimulus(40 + r, s, e, $urandom_range(1, 5), cidx);
            wait_done(300);
            repeat ($urandom_range(1, 3)) @(negedge clock);
        end
        rdy_rand = 1'b0;

        repeat (3) @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
